// File: rtl/avalon_st_pkt_fifo.sv
// avalon_st_pkt_fifo
//   Avalon-ST packet buffer with a framing sanitiser on the sink side. Well-formed
//   beats are written into a DEPTH-entry FIFO. Malformed beats are consumed but not
//   written, and each one is counted.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   snk_*                 Avalon-ST sink (ready latency 0)
//   src_*                 Avalon-ST source; all fields read 0 while src_valid_o=0
//   used_o                number of occupied FIFO entries
//   err_o                 1-cycle pulse, the cycle after a beat that violates framing
//   drop_cnt_o            saturating count of dropped beats
//
// Framing FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | between packets; only a sop beat is accepted into the FIFO
//   S_IN_PKT | inside a packet; beats must carry the latched channel
//   S_DROP   | rest of a corrupted packet is discarded until eop or a new sop
module avalon_st_pkt_fifo #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = $clog2(DWIDTH/8),
  parameter int DEPTH         = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DWIDTH-1:0]         snk_data_i,
  input  logic                      snk_valid_i,
  input  logic                      snk_sop_i,
  input  logic                      snk_eop_i,
  input  logic [EMPTY_WIDTH-1:0]    snk_empty_i,
  input  logic [CHANNEL_WIDTH-1:0]  snk_channel_i,
  output logic                      snk_ready_o,
  output logic [DWIDTH-1:0]         src_data_o,
  output logic                      src_valid_o,
  output logic                      src_sop_o,
  output logic                      src_eop_o,
  output logic [EMPTY_WIDTH-1:0]    src_empty_o,
  output logic [CHANNEL_WIDTH-1:0]  src_channel_o,
  input  logic                      src_ready_i,
  output logic [$clog2(DEPTH):0]    used_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_PKT = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DWIDTH-1:0]        data;
    logic                     sop;
    logic                     eop;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;
  } beat_t;

  beat_t                    mem [DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  state_t                   state, state_nxt;
  logic [CHANNEL_WIDTH-1:0] ch_q;
  logic [CNT_WIDTH-1:0]     drop_cnt_q;
  logic                     err_q;

  logic  full, empty, accept, rd_en, ch_match;
  logic  wr_en, drop, err_set, latch_ch;
  beat_t wr_beat, head;

  // Full when the pointers index the same slot but are one lap apart.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);

  // Ready stays low throughout reset, then depends only on fullness. A read in the
  // same cycle does not free up a slot for a write.
  assign snk_ready_o = !rst_i && !full;
  assign accept      = snk_valid_i && snk_ready_o;
  assign rd_en       = !empty && src_ready_i;
  assign ch_match    = (snk_channel_i == ch_q);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (snk_sop_i) begin
        // A sop always begins a new packet, whatever state the FSM is in.
        state_nxt = snk_eop_i ? S_IDLE : S_IN_PKT;
      end else begin
        case (state)
          S_IN_PKT: begin
            if (snk_eop_i)     state_nxt = S_IDLE;
            else if (!ch_match) state_nxt = S_DROP;
          end
          S_DROP:   if (snk_eop_i) state_nxt = S_IDLE;
          default:  state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Output logic: what to do with the accepted beat
  always_comb begin
    wr_en    = 1'b0;
    drop     = 1'b0;
    err_set  = 1'b0;
    latch_ch = 1'b0;
    if (accept) begin
      if (snk_sop_i) begin
        wr_en    = 1'b1;
        latch_ch = 1'b1;
        // A sop in the middle of a packet is flagged but still kept.
        err_set  = (state == S_IN_PKT);
      end else begin
        case (state)
          S_IN_PKT: begin
            if (ch_match) begin
              wr_en = 1'b1;
            end else begin
              drop    = 1'b1;
              err_set = 1'b1;
            end
          end
          // The error was already flagged on the beat that started the drop.
          S_DROP:  drop = 1'b1;
          default: begin
            drop    = 1'b1;
            err_set = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ch_q       <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en)    rd_ptr <= rd_ptr + PTR_ONE;
      if (latch_ch) ch_q   <= snk_channel_i;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_ONE;
      err_q <= err_set;
    end
  end

  // Empty is cleared on write so that the source never shows it without eop.
  always_comb begin
    wr_beat.data    = snk_data_i;
    wr_beat.sop     = snk_sop_i;
    wr_beat.eop     = snk_eop_i;
    wr_beat.empty   = snk_eop_i ? snk_empty_i : '0;
    wr_beat.channel = snk_channel_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_beat;
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign src_valid_o   = !empty;
  assign src_data_o    = src_valid_o ? head.data    : '0;
  assign src_sop_o     = src_valid_o ? head.sop     : 1'b0;
  assign src_eop_o     = src_valid_o ? head.eop     : 1'b0;
  assign src_empty_o   = src_valid_o ? head.empty   : '0;
  assign src_channel_o = src_valid_o ? head.channel : '0;

  assign used_o     = wr_ptr - rd_ptr;
  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// tb_avalon_st_pkt_fifo
//   Directed scenarios followed by random traffic. A queue-based reference model
//   predicts every output on every cycle.
module tb_avalon_st_pkt_fifo;

  localparam int DEPTH = 4;
  localparam int CNTW  = 12;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] snk_data_i = '0;
  logic        snk_valid_i = 1'b0, snk_sop_i = 1'b0, snk_eop_i = 1'b0;
  logic [2:0]  snk_empty_i = '0;
  logic [0:0]  snk_channel_i = '0;
  logic        snk_ready_o;
  logic [63:0] src_data_o;
  logic        src_valid_o, src_sop_o, src_eop_o;
  logic [2:0]  src_empty_o;
  logic [0:0]  src_channel_o;
  logic        src_ready_i = 1'b0;
  logic [2:0]  used_o;
  logic        err_o;
  logic [CNTW-1:0] drop_cnt_o;

  avalon_st_pkt_fifo #(
    .DWIDTH(64), .CHANNEL_WIDTH(1), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_empty_i(snk_empty_i), .snk_channel_i(snk_channel_i),
    .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_sop_o(src_sop_o),
    .src_eop_o(src_eop_o), .src_empty_o(src_empty_o), .src_channel_o(src_channel_o),
    .src_ready_i(src_ready_i),
    .used_o(used_o), .err_o(err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        ch;
  } beat_t;

  // Reference model: packet-level view of the stream.
  beat_t m_q[$];
  bit    m_in_pkt;     // a good packet is open
  bit    m_discard;    // remainder of a corrupted packet is being thrown away
  bit    m_ch;         // channel of the open packet
  bit    m_err;        // err_o expected this cycle
  int    m_drops;      // dropped beats, saturated at 2^CNTW-1

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_pkt  = 0;
    m_discard = 0;
    m_ch      = 0;
    m_err     = 0;
    m_drops   = 0;
  endtask

  task automatic model_drop();
    if (m_drops < (1 << CNTW) - 1) m_drops++;
  endtask

  // Decide what happens to one accepted beat.
  task automatic model_beat(input beat_t b, output bit err);
    beat_t w;
    err = 0;
    w = b;
    if (!b.eop) w.empty = 3'd0;
    if (b.sop) begin
      err       = m_in_pkt;
      m_in_pkt  = !b.eop;
      m_discard = 0;
      m_ch      = b.ch;
      m_q.push_back(w);
    end else if (m_discard) begin
      model_drop();
      if (b.eop) m_discard = 0;
    end else if (!m_in_pkt) begin
      model_drop();
      err = 1;
    end else if (b.ch == m_ch) begin
      m_q.push_back(w);
      if (b.eop) m_in_pkt = 0;
    end else begin
      model_drop();
      err       = 1;
      m_in_pkt  = 0;
      m_discard = !b.eop;
    end
  endtask

  task automatic check_outputs();
    chk("snk_ready", snk_ready_o, m_q.size() < DEPTH);
    chk("src_valid", src_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("src_data", src_data_o, m_q[0].data);
      chk("src_sop", src_sop_o, m_q[0].sop);
      chk("src_eop", src_eop_o, m_q[0].eop);
      chk("src_empty", src_empty_o, m_q[0].empty);
      chk("src_channel", src_channel_o, m_q[0].ch);
    end else begin
      chk("idle_fields", {src_data_o, src_sop_o, src_eop_o, src_empty_o, src_channel_o} == '0, 1'b1);
    end
    chk("used", used_o, m_q.size());
    chk("err", err_o, m_err);
    chk("drop_cnt", drop_cnt_o, m_drops);
  endtask

  // One clock cycle: drive at the falling edge, check before the rising edge,
  // then advance the model by what the rising edge will do.
  task automatic step(input logic v, input logic s, input logic e, input logic [2:0] em,
                      input logic ch, input logic [63:0] d, input logic r);
    beat_t b;
    bit acc, pop, err;
    snk_valid_i = v; snk_sop_i = s; snk_eop_i = e; snk_empty_i = em;
    snk_channel_i = ch; snk_data_i = d; src_ready_i = r;
    #1;
    check_outputs();
    acc = v && (m_q.size() < DEPTH);
    pop = (m_q.size() != 0) && r;
    if (pop) m_q.delete(0);
    err = 0;
    if (acc) begin
      b.data = d; b.sop = s; b.eop = e; b.empty = em; b.ch = ch;
      model_beat(b, err);
    end
    m_err = err;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 64'h0, r);
  endtask

  initial begin
    model_reset();
    #2;
    chk("ready_in_reset", snk_ready_o, 1'b0);
    chk("valid_in_reset", src_valid_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: three-beat packet on channel 1 with empty=3 on eop
    step(1, 1, 0, 3'd5, 1, 64'h1111_0000_0000_0001, 1);
    step(1, 0, 0, 3'd6, 1, 64'h2222_0000_0000_0002, 1);
    step(1, 0, 1, 3'd3, 1, 64'h3333_0000_0000_0003, 1);
    idle(3, 1);

    // 2: fill to DEPTH, then pop one while pushing
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1, 3'(i), 0, 64'hA0 + 64'(i), 0);
    chk("full_used", used_o, 3'd4);
    step(1, 1, 1, 3'd1, 1, 64'hBEEF, 1);
    step(1, 1, 1, 3'd1, 1, 64'hBEEF, 0);
    idle(1, 0);
    idle(6, 1);

    // 3: stray beat outside a packet
    step(1, 0, 0, 0, 0, 64'hAA, 1);
    idle(2, 1);

    // 4: channel change mid-packet
    step(1, 1, 0, 0, 0, 64'h40, 1);
    step(1, 0, 0, 0, 1, 64'h41, 1);
    step(1, 0, 0, 0, 0, 64'h42, 1);
    step(1, 0, 1, 2, 0, 64'h43, 1);
    step(1, 1, 0, 0, 0, 64'h50, 1);
    step(1, 0, 1, 4, 0, 64'h51, 1);
    idle(3, 1);

    // 5: sop inside a packet restarts it
    step(1, 1, 0, 0, 1, 64'h60, 1);
    step(1, 0, 0, 0, 1, 64'h61, 1);
    step(1, 1, 1, 7, 0, 64'h62, 1);
    step(1, 0, 0, 0, 0, 64'h63, 1);
    idle(3, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0), 3'($urandom), 1'($urandom_range(0, 7) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
    idle(8, 1);

    // 6: asynchronous reset mid-packet with two entries held
    step(1, 1, 0, 0, 1, 64'h70, 0);
    step(1, 0, 0, 0, 1, 64'h71, 0);
    chk("pre_reset_used", used_o, 3'd2);
    #3;
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", src_valid_o, 1'b0);
    chk("rst_used", used_o, 3'd0);
    chk("rst_ready", snk_ready_o, 1'b0);
    chk("rst_drop_cnt", drop_cnt_o, 0);
    chk("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5000; i++) step(1, 0, 0, 0, 1'($urandom), {$urandom, $urandom}, 1);
    idle(1, 1);
    chk("drop_saturated", drop_cnt_o, 12'hFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
